// File: rtl/and_vector_checker.sv
// On-chip stimulus generator and response checker for an AND user design.
// Walks every VEC_W-bit vector, waits SETTLE_CYC cycles, then compares the response.
module and_vector_checker #(
  parameter int unsigned VEC_W      = 8,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] stim_out,
  input  logic [VEC_W-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [VEC_W-1:0] first_fail,
  output logic             first_fail_valid
);

  localparam int unsigned HALF_W = VEC_W / 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ERR_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       settle_cnt;

  logic [VEC_W-1:0]       expected_c;
  logic                   mismatch_c;
  logic                   last_vec_c;
  logic                   err_sat_c;
  logic [ERR_W-1:0]       err_next_c;

  // Expected AND of the two stimulus halves, zero-extended to the bus width.
  always_comb begin
    expected_c = VEC_W'(stim_out[HALF_W-1:0] & stim_out[VEC_W-1:HALF_W]);
    mismatch_c = (resp_in != expected_c);
    last_vec_c = (stim_out == {VEC_W{1'b1}});
    err_sat_c  = (err_count == {ERR_W{1'b1}});
    err_next_c = (mismatch_c && !err_sat_c) ? err_count + ERR_W'(1) : err_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      stim_out         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      settle_cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= SETTLE;
            stim_out         <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            settle_cnt       <= CNT_W'(SETTLE_CYC - 1);
          end
        end

        SETTLE: begin
          if (abort) begin
            state      <= IDLE;
            stim_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            settle_cnt <= '0;
          end else if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end

        CHECK: begin
          if (abort) begin
            state      <= IDLE;
            stim_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            settle_cnt <= '0;
          end else begin
            err_count <= err_next_c;
            if (mismatch_c && !first_fail_valid) begin
              first_fail       <= stim_out;
              first_fail_valid <= 1'b1;
            end
            // Final vector ends the run; stim_out stays on all-ones.
            if (last_vec_c) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next_c == '0);
            end else begin
              state      <= SETTLE;
              stim_out   <= stim_out + VEC_W'(1);
              settle_cnt <= CNT_W'(SETTLE_CYC - 1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_vector_checker.sv
// Bench for and_vector_checker: a behavioural AND harness with selectable faults
// drives resp_in; full runs are scored against a per-vector reference model.
module tb_and_vector_checker;

  localparam int unsigned VEC_W      = 8;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int          RUN_CYC    = 256 * (SETTLE_CYC + 1);
  localparam int          MAX_CYC    = 2000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [VEC_W-1:0] stim_out;
  logic [VEC_W-1:0] resp_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_count;
  logic [VEC_W-1:0] first_fail;
  logic             first_fail_valid;

  int         mode;
  logic [7:0] corrupt [256];
  int         n_cmp;
  int         n_err;

  and_vector_checker #(.VEC_W(VEC_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .stim_out         (stim_out),
    .resp_in          (resp_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail       (first_fail),
    .first_fail_valid (first_fail_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Harness DUT: ideal AND, bit0 stuck-low, all-ones, or per-vector random corruption.
  always_comb begin
    logic [7:0] ideal;
    ideal = {4'h0, stim_out[3:0] & stim_out[7:4]};
    case (mode)
      0:       resp_in = ideal;
      1:       resp_in = ideal & 8'hFE;
      2:       resp_in = 8'hFF;
      default: resp_in = ideal ^ corrupt[stim_out];
    endcase
  end

  function automatic int harness_resp(input int m, input int v);
    int ideal;
    ideal = (v % 16) & (v / 16);
    case (m)
      0:       return ideal;
      1:       return ideal - (ideal % 2);
      2:       return 255;
      default: return ideal ^ int'(corrupt[v]);
    endcase
  endfunction

  // Reference: score all 256 vectors in order against the arithmetic AND of the nibbles.
  task automatic model(output int exp_err, output int exp_ff, output int exp_ffv);
    int raw;
    raw = 0; exp_ff = 0; exp_ffv = 0;
    for (int v = 0; v < 256; v++) begin
      if (harness_resp(mode, v) != ((v % 16) & (v / 16))) begin
        if (exp_ffv == 0) begin
          exp_ff  = v;
          exp_ffv = 1;
        end
        raw++;
      end
    end
    exp_err = (raw > 255) ? 255 : raw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run and follow it until done, an abort, or the cycle budget runs out.
  task automatic run(input int extra_at, input int abort_at, output int cyc);
    bit busy_ok;
    busy_ok = 1'b1;
    cyc     = 0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done_clear", 32'(done), 32'd0);
    chk("start_err_clear", 32'(err_count), 32'd0);
    chk("start_ffv_clear", 32'(first_fail_valid), 32'd0);
    chk("start_stim_zero", 32'(stim_out), 32'd0);
    while (!done && cyc < MAX_CYC) begin
      if (!busy) busy_ok = 1'b0;
      start = (cyc == extra_at);
      abort = (cyc == abort_at);
      if (cyc == abort_at)
        chk("abort_point_stim", 32'(stim_out), 32'(abort_at / (SETTLE_CYC + 1)));
      tick();
      cyc++;
      if (cyc == abort_at + 1) break;
    end
    start = 1'b0;
    abort = 1'b0;
    if (abort_at < 0) chk("busy_whole_run", 32'(busy_ok), 32'd1);
  endtask

  task automatic check_result(input string tag, input int cyc);
    int exp_err, exp_ff, exp_ffv;
    model(exp_err, exp_ff, exp_ffv);
    chk({tag, "_cycles"}, 32'(cyc), 32'(RUN_CYC));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
    chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
    chk({tag, "_ffv"}, 32'(first_fail_valid), 32'(exp_ffv));
    chk({tag, "_first_fail"}, 32'(first_fail), 32'(exp_ff));
    chk({tag, "_stim_last"}, 32'(stim_out), 32'hFF);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_stim"}, 32'(stim_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_ff"}, 32'(first_fail), 32'd0);
    chk({tag, "_ffv"}, 32'(first_fail_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_err = 0;
    mode  = 0;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 256; i++) corrupt[i] = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // 1: ideal harness, clean pass; abort while DONE changes nothing
    mode = 0;
    run(-1, -1, cyc);
    check_result("ideal", cyc);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    chk("abort_in_done_done", 32'(done), 32'd1);
    chk("abort_in_done_pass", 32'(pass), 32'd1);
    chk("done_hold_stim", 32'(stim_out), 32'hFF);

    // 2: bit0 stuck low
    mode = 1;
    run(-1, -1, cyc);
    check_result("stuck0", cyc);
    chk("stuck0_err_64", 32'(err_count), 32'd64);
    chk("stuck0_ff_11", 32'(first_fail), 32'h11);

    // 3: all-ones response saturates the error counter
    mode = 2;
    run(-1, -1, cyc);
    check_result("allff", cyc);
    chk("allff_err_sat", 32'(err_count), 32'd255);
    chk("allff_ff_00", 32'(first_fail), 32'h00);

    // 4: extra start while busy is ignored
    mode = 0;
    run(100, -1, cyc);
    check_result("extra_start", cyc);

    // 5: abort mid-run, then a clean run
    run(-1, 300, cyc);
    chk("abort_cycle", 32'(cyc), 32'd301);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_stim", 32'(stim_out), 32'd0);
    run(-1, -1, cyc);
    check_result("after_abort", cyc);

    // 6: asynchronous reset mid-run while errors are accumulating
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    chk("pre_reset_err_nonzero", 32'(err_count != 8'd0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    mode = 0;
    run(-1, -1, cyc);
    check_result("after_reset", cyc);

    // 7: random per-vector corruption with a random stray start
    for (int r = 0; r < 3; r++) begin
      mode = 3;
      for (int i = 0; i < 256; i++)
        corrupt[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run(int'($urandom_range(1, 700)), -1, cyc);
      check_result("random", cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
